// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: opcodes, FSM encoding and
// the opcode classifier used by the stall logic.
package mdu_pkg;

  localparam logic [5:0] MULT_OP = 6'b000010;
  localparam logic [5:0] DIV_OP  = 6'b000011;
  localparam logic [5:0] MFHI_OP = 6'b000100;
  localparam logic [5:0] MFLO_OP = 6'b000101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } mdu_state_e;

  // True for any opcode that reads or writes HI/LO through this unit.
  function automatic logic is_mdu_op(input logic [5:0] op);
    return (op == MULT_OP) || (op == DIV_OP) || (op == MFHI_OP) || (op == MFLO_OP);
  endfunction

endpackage

// File: rtl/mdu_restoring_div.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, keep the difference if it did not
// borrow. The quotient bit is the inverted borrow.
module mdu_restoring_div #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_dividend_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q_bit
);

  logic [WIDTH:0] w_partial;
  logic [WIDTH:0] w_diff;

  // Trial subtraction; the partial remainder stays below twice the divisor,
  // so bit WIDTH of the difference is exactly the borrow. A zero divisor never
  // borrows, which yields an all-ones quotient and remainder == dividend.
  always_comb begin
    w_partial = {i_rem, i_dividend_bit};
    w_diff    = w_partial - {1'b0, i_divisor};
    o_q_bit   = ~w_diff[WIDTH];
    o_rem     = o_q_bit ? w_diff[WIDTH-1:0] : w_partial[WIDTH-1:0];
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One shift-add or restoring-subtract step per clock, WIDTH steps per op.
// Build option: define MDU_SIGNED_EN for signed MULT/DIV (operand magnitudes
// with sign fix-up of the result); otherwise MULTU/DIVU semantics.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [5:0]       op_x,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic [5:0]       op_d,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mf_data,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             stall_req
);

  localparam int CNT_W = $clog2(WIDTH);

  mdu_state_e r_state, w_next_state;
  logic [CNT_W-1:0]   r_count;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_mcand, r_divisor, r_rem, r_quo;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_done, r_div_zero, r_zero_div;

  logic               w_accept, w_last;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
  logic [WIDTH:0]     w_add;
  logic [2*WIDTH-1:0] w_prod_next, w_prod_res;
  logic [WIDTH-1:0]   w_rem_next, w_quo_next, w_rem_res, w_quo_res;
  logic               w_q_bit;

  assign w_accept = (r_state == ST_IDLE) && start && ((op_x == MULT_OP) || (op_x == DIV_OP));
  assign w_last   = (r_count == CNT_W'(WIDTH - 1));

`ifdef MDU_SIGNED_EN
  logic r_neg_res, r_neg_rem;

  assign w_a_mag = rs_val[WIDTH-1] ? (~rs_val + 1'b1) : rs_val;
  assign w_b_mag = rt_val[WIDTH-1] ? (~rt_val + 1'b1) : rt_val;

  // Result signs are captured with the operands; inputs may change mid-op.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
    end else if (w_accept) begin
      r_neg_res <= rs_val[WIDTH-1] ^ rt_val[WIDTH-1];
      r_neg_rem <= rs_val[WIDTH-1];
    end
  end

  assign w_prod_res = r_neg_res ? (~w_prod_next + 1'b1) : w_prod_next;
  assign w_quo_res  = r_neg_res ? (~w_quo_next + 1'b1) : w_quo_next;
  assign w_rem_res  = r_neg_rem ? (~w_rem_next + 1'b1) : w_rem_next;
`else
  assign w_a_mag    = rs_val;
  assign w_b_mag    = rt_val;
  assign w_prod_res = w_prod_next;
  assign w_quo_res  = w_quo_next;
  assign w_rem_res  = w_rem_next;
`endif

  // Shift-add multiply step: add multiplicand into the upper half when the
  // current multiplier bit (LSB) is set, then shift the whole product right.
  assign w_add       = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
  assign w_prod_next = {w_add, r_prod[WIDTH-1:1]};

  mdu_restoring_div #(.WIDTH(WIDTH)) u_div_step (
    .i_rem          (r_rem),
    .i_dividend_bit (r_quo[WIDTH-1]),
    .i_divisor      (r_divisor),
    .o_rem          (w_rem_next),
    .o_q_bit        (w_q_bit)
  );
  assign w_quo_next = {r_quo[WIDTH-2:0], w_q_bit};

  // FSM state register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  // FSM next-state: launch on an accepted op, return to IDLE after the last step.
  // NOTE: default assignment first so no path leaves w_next_state unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept) w_next_state = (op_x == MULT_OP) ? ST_MUL : ST_DIV;
      ST_MUL,
      ST_DIV:  if (w_last) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // FSM outputs: busy for the whole in-flight window.
  always_comb begin
    busy = (r_state != ST_IDLE);
  end

  // Iteration datapath: load operands on accept, advance one step per edge.
  // NOTE: datapath registers are reset too, so an aborted op never leaves X state behind.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count    <= '0;
      r_prod     <= '0;
      r_mcand    <= '0;
      r_divisor  <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_zero_div <= 1'b0;
    end else if (w_accept) begin
      r_count    <= '0;
      r_prod     <= {{WIDTH{1'b0}}, w_b_mag};
      r_mcand    <= w_a_mag;
      r_divisor  <= w_b_mag;
      r_rem      <= '0;
      r_quo      <= w_a_mag;
      r_zero_div <= (rt_val == '0);
    end else if (r_state != ST_IDLE) begin
      r_count <= w_last ? '0 : r_count + 1'b1;
      if (r_state == ST_MUL) r_prod <= w_prod_next;
      if (r_state == ST_DIV) begin
        r_rem <= w_rem_next;
        r_quo <= w_quo_next;
      end
    end
  end

  // HI/LO commit and one-cycle completion pulses on the final step.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      if ((r_state != ST_IDLE) && w_last) begin
        r_done <= 1'b1;
        if (r_state == ST_MUL) begin
          r_hi <= w_prod_res[2*WIDTH-1:WIDTH];
          r_lo <= w_prod_res[WIDTH-1:0];
        end else begin
          r_hi       <= w_rem_res;
          r_lo       <= r_zero_div ? '1 : w_quo_res;
          r_div_zero <= r_zero_div;
        end
      end
    end
  end

  assign hi        = r_hi;
  assign lo        = r_lo;
  assign done      = r_done;
  assign div_zero  = r_div_zero;
  assign mf_data   = (op_x == MFHI_OP) ? r_hi : r_lo;
  assign stall_req = (busy | start) & is_mdu_op(op_d);

endmodule
